// File: rtl/grant_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : grant_lock_ctrl
// Purpose  : Locks shared-resource ownership to the arbiter's one-hot grant.
//            Ownership ends on release or on hold timeout, and timed-out
//            owners are masked from the arbiter. The optional macro
//            LOCK_COUNT_EN adds the lock_count output.
// Revision : 1.0  initial release
// ============================================================================
module grant_lock_ctrl #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic [3:0] grant_in,
   output logic [3:0] arb_req,
   output logic [3:0] lock_grant,
   output logic [1:0] owner_id,
   output logic       busy,
   output logic       timeout,
   output logic       onehot_err
`ifdef LOCK_COUNT_EN
   ,
   output logic [7:0] lock_count
`endif
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LOCKED  = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(MAX_HOLD - 1);
   localparam logic [CNT_W-1:0] c_cnt_max   = '1;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [3:0]       r_lock_grant, w_lock_grant_nxt;
   logic [1:0]       r_owner_id,   w_owner_id_nxt;
   logic             r_busy,       w_busy_nxt;
   logic             r_timeout,    w_timeout_nxt;
   logic             r_onehot_err, w_onehot_err_nxt;
   logic [CNT_W-1:0] r_hold_cnt,   w_hold_cnt_nxt;
   logic [3:0]       r_tmo_mask,   w_tmo_mask_nxt;
   logic             w_lock_taken;

   logic [2:0]       w_grant_cnt;
   logic [1:0]       w_grant_idx;
   logic             w_grant_onehot;
   logic             w_grant_multi;
   logic             w_grant_masked;
   logic             w_owner_req;
   logic             w_hold_expired;

   assign w_grant_cnt    = 3'(grant_in[0]) + 3'(grant_in[1]) + 3'(grant_in[2]) + 3'(grant_in[3]);
   assign w_grant_onehot = (w_grant_cnt == 3'd1);
   assign w_grant_multi  = (w_grant_cnt > 3'd1);
   assign w_grant_masked = |(grant_in & r_tmo_mask);
   assign w_grant_idx    = grant_in[3] ? 2'd3 :
                           grant_in[2] ? 2'd2 :
                           grant_in[1] ? 2'd1 : 2'd0;
   assign w_owner_req    = req[r_owner_id];
   assign w_hold_expired = (r_hold_cnt == c_hold_last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_lock_grant <= '0;
         r_owner_id   <= '0;
         r_busy       <= 1'b0;
         r_timeout    <= 1'b0;
         r_onehot_err <= 1'b0;
         r_hold_cnt   <= '0;
         r_tmo_mask   <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_lock_grant <= w_lock_grant_nxt;
         r_owner_id   <= w_owner_id_nxt;
         r_busy       <= w_busy_nxt;
         r_timeout    <= w_timeout_nxt;
         r_onehot_err <= w_onehot_err_nxt;
         r_hold_cnt   <= w_hold_cnt_nxt;
         r_tmo_mask   <= w_tmo_mask_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_lock_grant_nxt = r_lock_grant;
      w_owner_id_nxt   = r_owner_id;
      w_busy_nxt       = r_busy;
      w_timeout_nxt    = 1'b0;
      w_onehot_err_nxt = 1'b0;
      w_hold_cnt_nxt   = r_hold_cnt;
      // A mask bit survives only while its requester keeps asking.
      w_tmo_mask_nxt   = r_tmo_mask & req;
      w_lock_taken     = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_grant_multi) begin
               w_onehot_err_nxt = 1'b1;
            end else if (w_grant_onehot && !w_grant_masked) begin
               // A grant to a masked requester is refused outright.
               w_state_nxt      = S_LOCKED;
               w_lock_grant_nxt = grant_in;
               w_owner_id_nxt   = w_grant_idx;
               w_busy_nxt       = 1'b1;
               w_hold_cnt_nxt   = '0;
               w_tmo_mask_nxt   = '0;
               w_lock_taken     = 1'b1;
            end
         end

         S_LOCKED: begin
            w_hold_cnt_nxt = (r_hold_cnt == c_cnt_max) ? r_hold_cnt : r_hold_cnt + 1'b1;
            if (!w_owner_req || w_hold_expired) begin
               w_state_nxt      = S_RELEASE;
               w_lock_grant_nxt = '0;
               w_owner_id_nxt   = '0;
               w_busy_nxt       = 1'b0;
               w_hold_cnt_nxt   = '0;
               // Voluntary release takes precedence over a coincident timeout.
               if (w_owner_req) begin
                  w_timeout_nxt              = 1'b1;
                  w_tmo_mask_nxt[r_owner_id] = 1'b1;
               end
            end
         end

         S_RELEASE: begin
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign arb_req    = req & ~r_tmo_mask;
   assign lock_grant = r_lock_grant;
   assign owner_id   = r_owner_id;
   assign busy       = r_busy;
   assign timeout    = r_timeout;
   assign onehot_err = r_onehot_err;

`ifdef LOCK_COUNT_EN
   logic [7:0] r_lock_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lock_count <= '0;
      end else if (w_lock_taken) begin
         r_lock_count <= r_lock_count + 8'd1;
      end
   end

   assign lock_count = r_lock_count;
`endif

endmodule
`default_nettype wire
